// File: rtl/micro_sequencer.sv
// Microcode sequencer: IDLE -> PRIME -> RUN -> HALT, next-address logic with COND/IRD and BEN.
// Optional MSEQ_INT_EN enables the interrupt branch (COND=101); otherwise that condition acts as none.
module micro_sequencer #(
  parameter int AddrBusSize = 6,
  parameter int FETCH_ADDR  = 18
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  input  logic [51:0]            i_uinst,
  input  logic [15:0]            i_ir,
  input  logic [2:0]             i_nzp,
  input  logic                   i_mem_ready,
  input  logic                   i_psr15,
  input  logic                   i_int,
  input  logic                   i_acv,
  input  logic                   i_stall,
  input  logic                   i_halt_req,
  input  logic                   i_run,
  output logic                   o_read_en,
  output logic [AddrBusSize-1:0] o_read_addr,
  output logic                   o_uinst_valid,
  output logic [AddrBusSize-1:0] o_cur_addr,
  output logic                   o_halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [AddrBusSize-1:0] FetchAddr = AddrBusSize'(FETCH_ADDR);

  logic [1:0]             state;
  logic                   ben;
  logic                   halt_pend;
  logic                   ird;
  logic [2:0]             cond;
  logic [5:0]             j_field;
  logic                   ld_ben;
  logic [5:0]             j_mod;
  logic [AddrBusSize-1:0] next_addr;
  logic                   halt_now;
  logic                   leave_halt;

  assign ird     = i_uinst[51];
  assign cond    = i_uinst[50:48];
  assign j_field = i_uinst[47:42];
  assign ld_ben  = i_uinst[41];

`ifdef MSEQ_INT_EN
  logic unused_bits;
  assign unused_bits = ^{i_ir[8:0], i_uinst[40:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{i_ir[8:0], i_uinst[40:0], i_int};
`endif

  always_comb begin
    j_mod = j_field;
    case (cond)
      3'b001: j_mod[1] = j_field[1] | i_mem_ready;
      3'b010: j_mod[2] = j_field[2] | ben;
      3'b011: j_mod[0] = j_field[0] | i_ir[11];
      3'b100: j_mod[3] = j_field[3] | i_psr15;
`ifdef MSEQ_INT_EN
      3'b101: j_mod[4] = j_field[4] | i_int;
`endif
      3'b110: j_mod[5] = j_field[5] | i_acv;
      default: j_mod = j_field;
    endcase
  end

  assign next_addr = ird ? AddrBusSize'(i_ir[15:12]) : AddrBusSize'(j_mod);

  // A pending halt is taken only at an instruction boundary, i.e. when the next read would be the fetch.
  assign halt_now   = (state == S_RUN) && !i_stall && halt_pend && (next_addr == FetchAddr);
  assign leave_halt = (state == S_HALT) && !i_stall && i_run;

  assign o_read_en     = !i_stall && ((state == S_PRIME) || ((state == S_RUN) && !halt_now));
  assign o_uinst_valid = (state == S_RUN);
  assign o_halted      = (state == S_HALT);

  always_comb begin
    o_read_addr = o_cur_addr;
    if (!i_stall) begin
      if (state == S_PRIME)    o_read_addr = FetchAddr;
      else if (state == S_RUN) o_read_addr = next_addr;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state      <= S_IDLE;
      o_cur_addr <= '0;
      ben        <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      if (o_read_en) o_cur_addr <= o_read_addr;
      if ((state == S_RUN) && !i_stall && ld_ben)
        ben <= (i_ir[11] & i_nzp[2]) | (i_ir[10] & i_nzp[1]) | (i_ir[9] & i_nzp[0]);
      // Run wins over a simultaneous halt request; entering HALT consumes the request.
      if (halt_now || leave_halt) halt_pend <= 1'b0;
      else if (i_halt_req)        halt_pend <= 1'b1;
      if (!i_stall) begin
        case (state)
          S_IDLE:  state <= S_PRIME;
          S_PRIME: state <= S_RUN;
          S_RUN:   if (halt_now) state <= S_HALT;
          S_HALT:  if (i_run) state <= S_PRIME;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL provide parameter AddrBusSize, default 6: microaddress width.
REQ-002 SHALL provide parameter FETCH_ADDR, default 18: microaddress of first fetch state.
REQ-003 SHALL provide i_CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide i_RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide i_uinst  input  52  current microinstruction from the control store: [51]=IRD, [50:48]=COND, [47:42]=J, [41]=LD.BEN.
REQ-006 SHALL provide i_ir  input  16  instruction register.
REQ-007 SHALL provide i_nzp  input  3  condition codes {N,Z,P}.
REQ-008 SHALL provide i_mem_ready, i_psr15, i_int, i_acv  input  1 each  memory ready, privilege bit, interrupt request, access violation.
REQ-009 SHALL provide i_stall  input  1  freeze the sequencer for this cycle.
REQ-010 SHALL provide i_halt_req  input  1  request halt at the next instruction boundary.
REQ-011 SHALL provide i_run  input  1  leave HALT and restart at FETCH_ADDR.
REQ-012 SHALL provide o_read_en  output  1  control store read enable.
REQ-013 SHALL provide o_read_addr  output  AddrBusSize  next microaddress to the control store.
REQ-014 SHALL provide o_uinst_valid  output  1  i_uinst holds a valid microinstruction this cycle.
REQ-015 SHALL provide o_cur_addr  output  AddrBusSize  address of the microinstruction currently on i_uinst.
REQ-016 SHALL provide o_halted  output  1  sequencer is in HALT.

Function
REQ-017 The FSM SHALL have states IDLE, PRIME, RUN and HALT. IDLE->PRIME unconditionally, PRIME->RUN unconditionally, RUN->HALT per REQ-023, HALT->PRIME on i_run.
REQ-018 In PRIME, o_read_en SHALL be 1 and o_read_addr SHALL be FETCH_ADDR. o_uinst_valid SHALL be 1 from the next cycle onward, because the control store has 1-cycle read latency.
REQ-019 In RUN with i_stall=0, o_read_en SHALL be 1 and o_read_addr combinational. With IRD=1, o_read_addr SHALL be {2'b00, i_ir[15:12]}. With IRD=0, o_read_addr SHALL be J with one bit ORed per COND.
REQ-020 COND mapping SHALL be: 000 none; 001 J[1]|=i_mem_ready; 010 J[2]|=BEN; 011 J[0]|=i_ir[11]; 100 J[3]|=i_psr15; 101 J[4]|=i_int; 110 J[5]|=i_acv; 111 none.
REQ-021 BEN SHALL be an internal register loaded with (i_ir[11]&N)|(i_ir[10]&Z)|(i_ir[9]&P) on an edge where RUN, i_stall=0 and LD.BEN=1. The value is visible to COND=010 from the following cycle.
REQ-022 When i_stall=1, o_read_en SHALL be 0, o_read_addr SHALL equal o_cur_addr, and BEN, o_cur_addr and FSM state SHALL hold. The memory-ready wait SHALL use COND=001 self-loops, not i_stall.
REQ-023 i_halt_req SHALL set a sticky pending flag. In RUN, when the flag is set, i_stall=0 and the computed next address equals FETCH_ADDR, the FSM SHALL enter HALT instead of issuing the read. On entering HALT the flag SHALL clear.
REQ-024 In HALT, o_read_en=0, o_uinst_valid=0 and o_halted=1. If i_run and i_halt_req are asserted together in HALT, i_run SHALL win and the request SHALL be dropped.
REQ-025 o_cur_addr SHALL load o_read_addr on every edge where o_read_en=1.

Reset
REQ-026 While i_RST_N=0 at a clock edge, the FSM SHALL go to IDLE and o_read_en, o_uinst_valid and o_halted SHALL be 0. o_read_addr, o_cur_addr, BEN and the halt flag SHALL be 0.
REQ-027 Reset asserted mid-operation, including during a COND=001 wait, SHALL abort immediately. The first read after release SHALL be FETCH_ADDR, two cycles after release.

Configuration
REQ-028 With macro MSEQ_INT_EN defined, COND=101 SHALL behave per REQ-020.
REQ-029 Without MSEQ_INT_EN, COND=101 SHALL act as 000 and i_int SHALL be ignored, with no logic inferred for it.

Verification
REQ-030 Reset release -> o_read_addr=18 with o_read_en=1 in cycle 2, then o_uinst_valid=1 in cycle 3.
REQ-031 IRD=1, i_ir=16'h1xxx -> o_read_addr=1; i_ir=16'hFxxx -> 15.
REQ-032 COND=001, J=6'd33, i_mem_ready=0 for 3 cycles then 1 -> addr 33,33,33, then 35.
REQ-033 LD.BEN with i_ir[11:9]=3'b010, i_nzp=3'b010, next uinst COND=010, J=6'd22 -> o_read_addr=22 (BEN=1, J[2] already set); with i_nzp=3'b100 -> BEN=0, addr 22.
REQ-034 i_halt_req pulsed mid-instruction -> halt only when next addr=18, then o_halted=1 and o_read_en=0; i_run -> PRIME with addr 18.
REQ-035 COND=101, J=6'd0, i_int=1 -> addr 16 with MSEQ_INT_EN defined, addr 0 without it.
